// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the control unit.
//  - hzState_e  : hazard-controller FSM state encoding
//  - ctrlOut_t  : bundle of pipeline sequencing outputs (PC enable, IF-ID flush,
//                 per-stage enables En1..3 and bubble clears reset1..3)
//  - CTRL_*     : the five output patterns the controller can present
//  - *form      : RV32I major opcodes, shared with the control unit's decode
//  - decode helpers used by the control unit to derive id_use_rs1/rs2 and ex_is_load
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1
  } hzState_e;

  typedef struct packed {
    logic       pcEn;
    logic       ifidFlush;
    logic [3:1] en;
    logic [3:1] clr;
  } ctrlOut_t;

  // Reset: everything enabled and cleared so the whole pipeline holds NOPs.
  localparam ctrlOut_t CTRL_RESET    = '{pcEn: 1'b0, ifidFlush: 1'b1, en: 3'b111, clr: 3'b111};
  // Data memory busy: hold PC..EX-MEM, let WB drain with a bubble.
  localparam ctrlOut_t CTRL_FREEZE   = '{pcEn: 1'b0, ifidFlush: 1'b0, en: 3'b100, clr: 3'b100};
  // Taken branch/jump: load target, squash fetch and decode.
  localparam ctrlOut_t CTRL_REDIRECT = '{pcEn: 1'b1, ifidFlush: 1'b1, en: 3'b111, clr: 3'b001};
  // Load-use: hold PC/IF-ID, inject a bubble into stage1.
  localparam ctrlOut_t CTRL_BUBBLE   = '{pcEn: 1'b0, ifidFlush: 1'b0, en: 3'b111, clr: 3'b001};
  localparam ctrlOut_t CTRL_RUN      = '{pcEn: 1'b1, ifidFlush: 1'b0, en: 3'b111, clr: 3'b000};

  localparam logic [6:0] Iform    = 7'b0010011;
  localparam logic [6:0] Rform    = 7'b0110011;
  localparam logic [6:0] Sform    = 7'b0100011;
  localparam logic [6:0] LWform   = 7'b0000011;
  localparam logic [6:0] Brform   = 7'b1100011;
  localparam logic [6:0] UJform   = 7'b1101111;
  localparam logic [6:0] JALRform = 7'b1100111;

  function automatic logic decodeUsesRs1(input logic [6:0] op);
    return (op == Iform) || (op == Rform) || (op == Sform) ||
           (op == LWform) || (op == Brform) || (op == JALRform);
  endfunction

  function automatic logic decodeUsesRs2(input logic [6:0] op);
    return (op == Rform) || (op == Sform) || (op == Brform);
  endfunction

  function automatic logic decodeIsLoad(input logic [6:0] op);
    return op == LWform;
  endfunction

  function automatic logic decodeIsJump(input logic [6:0] op);
    return (op == UJform) || (op == JALRform);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath/control unit and the hazard
// controller.
//  master : pipeline side - drives decode/stage1/stage2 hazard inputs,
//           consumes sequencing outputs
//  slave  : hazard controller - consumes hazard inputs, drives pc_en,
//           ifid_flush, En1..3, reset1..3 and the stall_cnt debug counter
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              ex_redirect;
  logic              mem_req;
  logic              mem_ready;

  logic              pc_en;
  logic              ifid_flush;
  logic              En1;
  logic              En2;
  logic              En3;
  logic              reset1;
  logic              reset2;
  logic              reset3;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_redirect, mem_req, mem_ready,
    input  pc_en, ifid_flush, En1, En2, En3, reset1, reset2, reset3, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_redirect, mem_req, mem_ready,
    output pc_en, ifid_flush, En1, En2, En3, reset1, reset2, reset3, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare.
//  idRs1/idRs2       : source registers of the instruction in decode
//  idUseRs1/idUseRs2 : decode instruction actually reads that source
//  exRd, exIsLoad    : destination and load flag of the instruction in stage1
//  luHit             : decode needs a value stage1 has not loaded yet
// x0 is hard-wired zero, so a load targeting it never creates a dependency.
module pipeline_hazard_ctrl_hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] idRs1,
  input  logic [REG_AW-1:0] idRs2,
  input  logic              idUseRs1,
  input  logic              idUseRs2,
  input  logic [REG_AW-1:0] exRd,
  input  logic              exIsLoad,
  output logic              luHit
);
  logic rs1Match;
  logic rs2Match;

  assign rs1Match = idUseRs1 && (idRs1 == exRd);
  assign rs2Match = idUseRs2 && (idRs2 == exRd);
  assign luHit    = exIsLoad && (exRd != '0) && (rs1Match || rs2Match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 4-register pipeline.
// Ports:
//  clock  : single clock, all state on the rising edge
//  resetn : synchronous reset, active-high despite the name
//  hz     : slave side of pipeline_hazard_ctrl_if (hazard inputs in,
//           pc_en / ifid_flush / En1..3 / reset1..3 / stall_cnt out)
// Outputs are combinational from registered state and current inputs.
// Per-cycle priority: reset > memory wait > redirect > load-use > run.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] LU_RELOAD = 2'(LU_BUBBLES - 1);

  hzState_e         state;
  hzState_e         stateNext;
  logic [1:0]       luCnt;
  logic [1:0]       luCntNext;
  logic             luHit;
  logic             memWait;
  ctrlOut_t         ctrl;
  logic [CNT_W-1:0] stallCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pipeline_hazard_ctrl_hazard_detect #(.REG_AW(REG_AW)) uHazardDetect (
    .idRs1    (hz.id_rs1),
    .idRs2    (hz.id_rs2),
    .idUseRs1 (hz.id_use_rs1),
    .idUseRs2 (hz.id_use_rs2),
    .exRd     (hz.ex_rd),
    .exIsLoad (hz.ex_is_load),
    .luHit    (luHit)
  );

  assign memWait = hz.mem_req && !hz.mem_ready;

  always_ff @(posedge clock) begin
    if (resetn) begin
      state <= RUN;
      luCnt <= 2'd0;
    end else begin
      state <= stateNext;
      luCnt <= luCntNext;
    end
  end

  always_comb begin
    stateNext = state;
    luCntNext = luCnt;
    if (memWait) begin
      // Frozen pipeline: the pending bubble count waits with it.
      stateNext = state;
      luCntNext = luCnt;
    end else if (hz.ex_redirect) begin
      // The stalled decode instruction is squashed, so its bubbles are moot.
      stateNext = RUN;
      luCntNext = 2'd0;
    end else if (state == LU_STALL) begin
      if (luCnt == 2'd1) begin
        stateNext = RUN;
        luCntNext = 2'd0;
      end else begin
        luCntNext = luCnt - 2'd1;
      end
    end else if (luHit && (LU_BUBBLES > 1)) begin
      stateNext = LU_STALL;
      luCntNext = LU_RELOAD;
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (resetn) begin
      ctrl = CTRL_RESET;
    end else if (memWait) begin
      ctrl = CTRL_FREEZE;
    end else if (hz.ex_redirect) begin
      ctrl = CTRL_REDIRECT;
    end else if ((state == LU_STALL) || luHit) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  // Counts cycles the PC is held; reset cycles themselves are not counted.
  always_ff @(posedge clock) begin
    if (resetn) begin
      stallCnt <= '0;
    end else if (!ctrl.pcEn) begin
      stallCnt <= satInc(stallCnt);
    end
  end

  assign hz.pc_en      = ctrl.pcEn;
  assign hz.ifid_flush = ctrl.ifidFlush;
  assign hz.En1        = ctrl.en[1];
  assign hz.En2        = ctrl.en[2];
  assign hz.En3        = ctrl.en[3];
  assign hz.reset1     = ctrl.clr[1];
  assign hz.reset2     = ctrl.clr[2];
  assign hz.reset3     = ctrl.clr[3];
  assign hz.stall_cnt  = stallCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl. Two builds run side by side on identical
// inputs: A (LU_BUBBLES=1, CNT_W=16) and B (LU_BUBBLES=3, CNT_W=4).
// Stimulus pushes the hand-derived output pattern for each cycle into a queue;
// a monitor on the falling edge pops and compares.
module tb_pipeline_hazard_ctrl;

  // Flag order: {pc_en, ifid_flush, En1, En2, En3, reset1, reset2, reset3}
  localparam logic [7:0] F_RST  = 8'b0111_1111;
  localparam logic [7:0] F_NORM = 8'b1011_1000;
  localparam logic [7:0] F_MW   = 8'b0000_1001;
  localparam logic [7:0] F_RD   = 8'b1111_1100;
  localparam logic [7:0] F_LU   = 8'b0011_1100;

  typedef struct {
    logic [7:0]  fa;
    logic [15:0] ca;
    logic [7:0]  fb;
    logic [3:0]  cb;
    logic        chkCnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) hzA ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hzB ();

  pipeline_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(1), .CNT_W(16)) dutA (
    .clock (clk), .resetn (rst), .hz (hzA.slave)
  );
  pipeline_hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(3), .CNT_W(4)) dutB (
    .clock (clk), .resetn (rst), .hz (hzB.slave)
  );

  exp_t        expQ[$];
  int          total  = 0;
  int          passed = 0;
  int          vecNo  = 0;
  logic [15:0] cntA   = '0;
  logic [3:0]  cntB   = '0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req)
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      chk("flagsA", e.idx, {8'h0, hzA.pc_en, hzA.ifid_flush, hzA.En1, hzA.En2, hzA.En3,
                            hzA.reset1, hzA.reset2, hzA.reset3}, {8'h0, e.fa});
      chk("flagsB", e.idx, {8'h0, hzB.pc_en, hzB.ifid_flush, hzB.En1, hzB.En2, hzB.En3,
                            hzB.reset1, hzB.reset2, hzB.reset3}, {8'h0, e.fb});
      if (e.chkCnt) begin
        chk("stallCntA", e.idx, hzA.stall_cnt, e.ca);
        chk("stallCntB", e.idx, {12'h0, hzB.stall_cnt}, {12'h0, e.cb});
      end
    end
  end

  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                       input logic rdr, input logic mreq, input logic mrdy);
    rst = r;
    hzA.id_rs1 = rs1;  hzB.id_rs1 = rs1;
    hzA.id_rs2 = rs2;  hzB.id_rs2 = rs2;
    hzA.id_use_rs1 = u1;  hzB.id_use_rs1 = u1;
    hzA.id_use_rs2 = u2;  hzB.id_use_rs2 = u2;
    hzA.ex_rd = rd;  hzB.ex_rd = rd;
    hzA.ex_is_load = ld;  hzB.ex_is_load = ld;
    hzA.ex_redirect = rdr;  hzB.ex_redirect = rdr;
    hzA.mem_req = mreq;  hzB.mem_req = mreq;
    hzA.mem_ready = mrdy;  hzB.mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic loadUse();
    drive(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic memWait();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Record the expectation for the cycle now being driven, advance the
  // expected stall counters, then move to the next cycle.
  task automatic issue(input logic [7:0] fa, input logic [7:0] fb, input logic chkCnt);
    exp_t e;
    e.fa = fa;  e.ca = cntA;  e.fb = fb;  e.cb = cntB;
    e.chkCnt = chkCnt;  e.idx = vecNo;
    expQ.push_back(e);
    vecNo++;
    if (rst) begin
      cntA = '0;
      cntB = '0;
    end else begin
      if (!fa[7] && cntA != 16'hFFFF) cntA = cntA + 16'd1;
      if (!fb[7] && cntB != 4'hF)     cntB = cntB + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    // Reset held two cycles, then release.
    issue(F_RST, F_RST, 1'b1);
    issue(F_RST, F_RST, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Load-use via rs2: A one bubble, B three.
    loadUse();   issue(F_LU, F_LU, 1'b1);
    idle();      issue(F_NORM, F_LU, 1'b1);
    idle();      issue(F_NORM, F_LU, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Load into x0 and loads whose rd is not read: no hazard.
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(F_NORM, F_NORM, 1'b1);
    drive(1'b0, 5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(F_NORM, F_NORM, 1'b1);
    // Load-use via rs1.
    drive(1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(F_LU, F_LU, 1'b1);
    idle();      issue(F_NORM, F_LU, 1'b1);
    idle();      issue(F_NORM, F_LU, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Four-cycle memory wait, then completion.
    for (int i = 0; i < 4; i++) begin
      memWait(); issue(F_MW, F_MW, 1'b1);
    end
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(F_NORM, F_NORM, 1'b1);
    // Redirect beats a simultaneous load-use.
    drive(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(F_RD, F_RD, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Redirect abandons B's pending bubbles.
    loadUse();   issue(F_LU, F_LU, 1'b1);
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(F_RD, F_RD, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Redirect during memory wait: freeze only, flush when memory completes.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      issue(F_MW, F_MW, 1'b1);
    end
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    issue(F_RD, F_RD, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Memory wait holds B's bubble countdown.
    loadUse();   issue(F_LU, F_LU, 1'b1);
    memWait();   issue(F_MW, F_MW, 1'b1);
    idle();      issue(F_NORM, F_LU, 1'b1);
    idle();      issue(F_NORM, F_LU, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    // Long wait: B's 4-bit counter pins at 15.
    for (int i = 0; i < 20; i++) begin
      memWait(); issue(F_MW, F_MW, 1'b1);
    end
    // Reset in the middle of a wait wins and clears the counters.
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(F_RST, F_RST, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    idle();      issue(F_NORM, F_NORM, 1'b1);
    @(negedge clk);
    #1;
    total++;
    if (expQ.size() != 0)
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
